stack_arbiter: RTL and testbench

Shares one `stack` instance between `NREQ` independent requesters. Each requester posts a push or pop request. The block picks one round-robin, drives a single-cycle `push`/`pop` command into the stack, waits out the stack's fixed command latency, then returns an acknowledge with pop data or an error flag. It sits between client logic and the stack and is the only driver of the stack's `push`, `pop` and `data_in`.

---
 rtl/stack_arb_pkg.sv | 20 ++
 rtl/stack_arbiter_if.sv | 32 +++
 rtl/stack_arbiter_rr_pick.sv | 30 +++
 rtl/stack_arbiter.sv | 112 +++++++++++
 tb/tb_stack_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_arb_pkg.sv
// Shared types and helpers for the stack arbiter: FSM state encoding, op codes
// and an index-width helper.
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// Bundle of requester-side and stack-side signals around the arbiter.
// The arbiter takes the slave view; the surrounding logic takes the master view.
interface stack_arbiter_if #(
  parameter int WIDTH = 2,
  parameter int NREQ  = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic [WIDTH-1:0]      resp_data;
  logic                  busy;
  logic                  stk_push;
  logic                  stk_pop;
  logic [WIDTH-1:0]      stk_data_in;
  logic [WIDTH-1:0]      stk_data_out;
  logic                  stk_full;
  logic                  stk_empty;

  modport slave (
    input  req_valid, req_op, req_data, stk_data_out, stk_full, stk_empty,
    output ack, err, resp_data, busy, stk_push, stk_pop, stk_data_in
  );

  modport master (
    output req_valid, req_op, req_data, stk_data_out, stk_full, stk_empty,
    input  ack, err, resp_data, busy, stk_push, stk_pop, stk_data_in
  );

endinterface

// File: rtl/stack_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit searching upward
// from ptr+1, wrapping modulo NREQ.
module rr_pick
  import stack_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   grant,
  output logic            any
);

  // Walk the candidates from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        grant = PW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack among NREQ requesters: issues a single
// push/pop pulse, waits out the stack latency, then acks with data or an error.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int NREQ        = 2,
  parameter int WAIT_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  stack_arbiter_if.slave  bus
);

  localparam int PW = idx_width(NREQ);
  localparam int CW = idx_width(WAIT_CYCLES);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant_idx;
  logic             op;
  logic [CW-1:0]    count;

  logic [PW-1:0]    pick;
  logic             pick_any;
  logic             pick_op;
  logic [WIDTH-1:0] pick_data;
  logic             pick_fail;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick),
    .any   (pick_any)
  );

  assign pick_op   = bus.req_op[pick];
  assign pick_data = bus.req_data[int'(pick)*WIDTH +: WIDTH];
  assign pick_fail = (pick_op == OP_PUSH) ? bus.stk_full : bus.stk_empty;

  // A request the stack cannot honour skips the command and goes straight to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= PW'(NREQ - 1);
      grant_idx       <= '0;
      op              <= OP_PUSH;
      count           <= '0;
      bus.ack         <= '0;
      bus.err         <= 1'b0;
      bus.resp_data   <= '0;
      bus.busy        <= 1'b0;
      bus.stk_push    <= 1'b0;
      bus.stk_pop     <= 1'b0;
      bus.stk_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_idx <= pick;
            op        <= pick_op;
            ptr       <= pick;
            bus.busy  <= 1'b1;
            if (pick_fail) begin
              state         <= DONE;
              bus.ack       <= '0;
              bus.ack[pick] <= 1'b1;
              bus.err       <= 1'b1;
            end else begin
              state           <= ISSUE;
              bus.stk_push    <= (pick_op == OP_PUSH);
              bus.stk_pop     <= (pick_op == OP_POP);
              bus.stk_data_in <= (pick_op == OP_PUSH) ? pick_data : '0;
            end
          end
        end

        ISSUE: begin
          bus.stk_push <= 1'b0;
          bus.stk_pop  <= 1'b0;
          count        <= CW'(WAIT_CYCLES - 1);
          state        <= WAIT;
        end

        WAIT: begin
          if (count == '0) begin
            if (op == OP_POP) begin
              bus.resp_data <= bus.stk_data_out;
            end
            bus.ack            <= '0;
            bus.ack[grant_idx] <= 1'b1;
            bus.err            <= 1'b0;
            bus.stk_data_in    <= '0;
            state              <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end

        DONE: begin
          bus.ack  <= '0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: a transaction-level reference model with
// per-cycle comparison, plus directed scenarios with hand-computed expectations.
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int WIDTH       = 2;
  localparam int NREQ        = 2;
  localparam int WAIT_CYCLES = 3;
  localparam int DEPTH       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests    = 0;
  int   failures = 0;
  bit   checking = 1'b0;

  always #5 clk = ~clk;

  stack_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  stack_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Simple stack of DEPTH words; pop data appears on the edge after the pop.
  logic [WIDTH-1:0] mem [DEPTH];
  int               cnt;

  always @(posedge clk) begin
    if (rst) begin
      cnt              <= 0;
      bus.stk_data_out <= '0;
    end else if (bus.stk_push && cnt < DEPTH) begin
      mem[cnt] <= bus.stk_data_in;
      cnt      <= cnt + 1;
    end else if (bus.stk_pop && cnt > 0) begin
      bus.stk_data_out <= mem[cnt-1];
      cnt              <= cnt - 1;
    end
  end

  assign bus.stk_full  = (cnt == DEPTH);
  assign bus.stk_empty = (cnt == 0);

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model: an operation is a timeline measured from its grant cycle.
  bit               mActive;
  int               mElapsed;
  int               mDone;
  int               mReq;
  int               mPtr;
  int               mIdx;
  bit               mOp;
  bit               mErr;
  logic [WIDTH-1:0] mData;
  logic [WIDTH-1:0] mPopVal;
  logic [WIDTH-1:0] mResp;
  logic [WIDTH-1:0] mq [$];

  always @(posedge clk) begin
    if (rst) begin
      mActive  = 1'b0;
      mElapsed = 0;
      mPtr     = NREQ - 1;
      mResp    = '0;
      mq.delete();
    end else if (mActive) begin
      mElapsed++;
      if (mElapsed == mDone && !mErr && mOp == OP_POP) mResp = mPopVal;
      if (mElapsed > mDone) mActive = 1'b0;
    end else if (bus.req_valid != '0) begin
      mReq = -1;
      for (int k = 1; k <= NREQ; k++) begin
        mIdx = (mPtr + k) % NREQ;
        if (mReq < 0 && bus.req_valid[mIdx]) mReq = mIdx;
      end
      mOp   = bus.req_op[mReq];
      mData = bus.req_data[mReq*WIDTH +: WIDTH];
      mPtr  = mReq;
      mErr  = (mOp == OP_PUSH) ? (mq.size() == DEPTH) : (mq.size() == 0);
      if (!mErr) begin
        if (mOp == OP_PUSH) mq.push_back(mData);
        else mPopVal = mq.pop_back();
      end
      mDone    = mErr ? 1 : 2 + WAIT_CYCLES;
      mElapsed = 1;
      mActive  = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit eCmd;
    int eAck;
    int eDin;
    if (checking) begin
      eCmd = mActive && !mErr && mElapsed == 1;
      eAck = (mActive && mElapsed == mDone) ? (1 << mReq) : 0;
      eDin = (mActive && !mErr && mOp == OP_PUSH && mElapsed >= 1 && mElapsed <= 1 + WAIT_CYCLES)
             ? int'(mData) : 0;
      checkOutput("ack",         int'(bus.ack),         eAck);
      checkOutput("err",         int'(bus.err),         int'(mActive && mElapsed == mDone && mErr));
      checkOutput("busy",        int'(bus.busy),        int'(mActive));
      checkOutput("stk_push",    int'(bus.stk_push),    int'(eCmd && mOp == OP_PUSH));
      checkOutput("stk_pop",     int'(bus.stk_pop),     int'(eCmd && mOp == OP_POP));
      checkOutput("stk_data_in", int'(bus.stk_data_in), eDin);
      checkOutput("resp_data",   int'(bus.resp_data),   int'(mResp));
    end
  end

  // Post one request from a lone requester and check latency, command and result.
  task automatic applyStimulus(input int req, input bit op, input logic [WIDTH-1:0] data,
                               input int expLat, input bit expErr,
                               input bit checkResp, input logic [WIDTH-1:0] expResp);
    int               k;
    int               cmdAt;
    logic [WIDTH-1:0] cmdData;
    bit               seen;
    @(posedge clk);
    #1;
    bus.req_valid                       = '0;
    bus.req_valid[req]                  = 1'b1;
    bus.req_op[req]                     = op;
    bus.req_data[req*WIDTH +: WIDTH]    = data;
    k       = 0;
    cmdAt   = -1;
    cmdData = '0;
    seen    = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (cmdAt < 0 && (bus.stk_push || bus.stk_pop)) begin
        cmdAt   = k;
        cmdData = bus.stk_data_in;
      end
      if (bus.ack != '0) seen = 1'b1;
      else k++;
    end
    bus.req_valid = '0;
    checkOutput("ackSeen",    int'(seen),     1);
    checkOutput("ackLatency", k,              expLat);
    checkOutput("ackVector",  int'(bus.ack),  1 << req);
    checkOutput("ackErr",     int'(bus.err),  int'(expErr));
    checkOutput("cmdCycle",   cmdAt,          expErr ? -1 : 1);
    if (!expErr && op == OP_PUSH) checkOutput("cmdData", int'(cmdData), int'(data));
    if (checkResp) checkOutput("respData", int'(bus.resp_data), int'(expResp));
  endtask

  int ackVec [4];
  int ackAt  [4];
  int n;
  int k;

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_data  = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 checking = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetBusy", int'(bus.busy),        0);
    checkOutput("resetAck",  int'(bus.ack),         0);
    checkOutput("resetResp", int'(bus.resp_data),   0);
    checkOutput("resetPush", int'(bus.stk_push),    0);

    applyStimulus(0, OP_PUSH, 2'b10, 5, 1'b0, 1'b0, 2'b00);
    applyStimulus(0, OP_POP,  2'b00, 5, 1'b0, 1'b1, 2'b10);
    applyStimulus(1, OP_POP,  2'b00, 1, 1'b1, 1'b1, 2'b10);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(i % 2, OP_PUSH, WIDTH'(i % 4), 5, 1'b0, 1'b0, 2'b00);
    end
    applyStimulus(0, OP_PUSH, 2'b01, 1, 1'b1, 1'b0, 2'b00);
    applyStimulus(1, OP_POP,  2'b00, 5, 1'b0, 1'b1, 2'b11);

    // Both requesters hold pops continuously; remaining stack is 0,1,2,3,0,1,2.
    @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    bus.req_op    = 2'b11;
    n = 0;
    k = 0;
    while (n < 4 && k < 60) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        ackVec[n] = int'(bus.ack);
        ackAt[n]  = k;
        n++;
        if (n == 4) bus.req_valid = '0;
      end
      k++;
    end
    bus.req_valid = '0;
    checkOutput("holdCount", n, 4);
    checkOutput("holdFirst", ackAt[0], 5);
    for (int i = 0; i < 4; i++) checkOutput("holdGrant", ackVec[i], (i % 2 == 0) ? 1 : 2);
    for (int i = 1; i < 4; i++) checkOutput("holdSpacing", ackAt[i] - ackAt[i-1], 6);
    checkOutput("holdResp", int'(bus.resp_data), 3);

    // Abort a push while it sits in WAIT.
    @(posedge clk);
    #1;
    bus.req_valid    = 2'b01;
    bus.req_op[0]    = OP_PUSH;
    bus.req_data[1:0] = 2'b11;
    repeat (4) @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    checkOutput("abortBusy", int'(bus.busy),        0);
    checkOutput("abortAck",  int'(bus.ack),         0);
    checkOutput("abortErr",  int'(bus.err),         0);
    checkOutput("abortPush", int'(bus.stk_push),    0);
    checkOutput("abortDin",  int'(bus.stk_data_in), 0);
    checkOutput("abortResp", int'(bus.resp_data),   0);
    rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ack != '0) n++;
    end
    checkOutput("abortNoAck", n, 0);

    applyStimulus(0, OP_PUSH, 2'b01, 5, 1'b0, 1'b0, 2'b00);
    applyStimulus(1, OP_POP,  2'b00, 5, 1'b0, 1'b1, 2'b01);

    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
